// File: rtl/md_io_pkg.sv
// md_io_pkg: register map, reset values and address decode
// shared by md_io_regs and its port channels.
package md_io_pkg;

    localparam logic [3:0] A_VERSION = 4'd0;
    localparam logic [3:0] A_DATA1   = 4'd1;
    localparam logic [3:0] A_CTRL1   = 4'd4;
    localparam logic [3:0] A_TX1     = 4'd7;
    localparam logic [3:0] SER_STEP  = 4'd3;

    localparam logic [7:0] DATA_RST   = 8'h00;
    localparam logic [7:0] CTRL_RST   = 8'h00;
    localparam logic [7:0] TX_RST     = 8'hFF;
    localparam logic [7:0] SCTRL_RST  = 8'h00;
    localparam logic [7:0] DOUT_RST   = 8'h00;
    localparam logic [6:0] PORT_RST   = 7'h00;
    localparam logic [6:0] PORT3_PINS = 7'h7F;

    typedef enum logic [2:0] {
        K_VER,
        K_DATA,
        K_CTRL,
        K_TX,
        K_RX,
        K_SCTRL
    } reg_kind_e;

    typedef struct packed {
        reg_kind_e  kind;
        logic [1:0] ch;
    } reg_dec_t;

    // Serial registers repeat as TX/RX/SCTRL triplets from A_TX1 upward.
    function automatic reg_dec_t reg_decode(input logic [3:0] a);
        reg_dec_t   d;
        logic [3:0] off;
        d.kind = K_VER;
        d.ch   = 2'd0;
        off    = a - A_TX1;
        unique case (1'b1)
            (a == A_VERSION): d.kind = K_VER;
            (a >= A_DATA1 && a < A_CTRL1): begin
                d.kind = K_DATA;
                d.ch   = 2'(a - A_DATA1);
            end
            (a >= A_CTRL1 && a < A_TX1): begin
                d.kind = K_CTRL;
                d.ch   = 2'(a - A_CTRL1);
            end
            (a >= A_TX1): begin
                d.ch = 2'(off / SER_STEP);
                unique case (off % SER_STEP)
                    4'd0:    d.kind = K_TX;
                    4'd1:    d.kind = K_RX;
                    default: d.kind = K_SCTRL;
                endcase
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/io_port_channel.sv
// io_port_channel: one controller port -- DATA/CTRL/TX/SCTRL
// storage, read mux and TH falling-edge detect.
module io_port_channel
    import md_io_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       wr,
    input  reg_kind_e  kind,
    input  logic [7:0] din,
    input  logic [6:0] pins,
    output logic [7:0] rdata,
    output logic [6:0] port_in,
    output logic [6:0] port_dir,
    output logic       th_event
);

    logic [7:0] data;
    logic [7:0] ctrl;
    logic [7:0] tx;
    logic [4:0] sctrl;
    logic       th_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data  <= DATA_RST;
            ctrl  <= CTRL_RST;
            tx    <= TX_RST;
            sctrl <= SCTRL_RST[7:3];
            th_q  <= 1'b1;
        end else begin
            th_q <= pins[6];
            if (wr) begin
                case (kind)
                    K_DATA:  data  <= din;
                    K_CTRL:  ctrl  <= din;
                    K_TX:    tx    <= din;
                    K_SCTRL: sctrl <= din[7:3];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (kind)
            K_DATA:  rdata = {data[7],
                              (ctrl[6:0] & data[6:0]) |
                              (~ctrl[6:0] & pins)};
            K_CTRL:  rdata = ctrl;
            K_TX:    rdata = tx;
            K_SCTRL: rdata = {sctrl, 3'b000};
            default: rdata = '0;
        endcase
    end

    // Judged against the stored CTRL, so a same-cycle CTRL write has no say.
    assign th_event = ctrl[7] & ~ctrl[6] & th_q & ~pins[6];

    assign port_in  = data[6:0];
    assign port_dir = ctrl[6:0];

endmodule

// File: rtl/md_io_regs.sv
// md_io_regs: Mega Drive I/O register block -- address decode,
// VERSION, registered read data and external interrupt flag.
module md_io_regs
    import md_io_pkg::*;
#(
    parameter bit         EXPORT = 1'b1,
    parameter logic [3:0] HW_VER = 4'd0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       PAL,
    input  logic       sel,
    input  logic       we,
    input  logic [3:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic [6:0] port1_pins,
    input  logic [6:0] port2_pins,
    output logic [6:0] port1_in,
    output logic [6:0] port2_in,
    output logic [6:0] port1_dir,
    output logic [6:0] port2_dir,
    output logic       ext_irq,
    input  logic       irq_ack
);

    reg_dec_t   dec;
    logic [7:0] version;
    logic [7:0] rd;
    logic [7:0] ch_rdata [3];
    logic [6:0] ch_pins  [3];
    logic [6:0] ch_in    [3];
    logic [6:0] ch_dir   [3];
    logic [2:0] ch_ev;
    logic       unused_p3;

    assign dec     = reg_decode(addr);
    assign version = {EXPORT, PAL, 1'b1, 1'b0, HW_VER};

    assign ch_pins[0] = port1_pins;
    assign ch_pins[1] = port2_pins;
    assign ch_pins[2] = PORT3_PINS;

    for (genvar i = 0; i < 3; i++) begin : g_ch
        io_port_channel u_ch (
            .clk,
            .reset_n,
            .wr       (sel && we && dec.ch == 2'(i)),
            .kind     (dec.kind),
            .din,
            .pins     (ch_pins[i]),
            .rdata    (ch_rdata[i]),
            .port_in  (ch_in[i]),
            .port_dir (ch_dir[i]),
            .th_event (ch_ev[i])
        );
    end

    always_comb begin
        rd = version;
        if (dec.kind != K_VER) begin
            case (dec.ch)
                2'd0:    rd = ch_rdata[0];
                2'd1:    rd = ch_rdata[1];
                default: rd = ch_rdata[2];
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout    <= DOUT_RST;
            ext_irq <= 1'b0;
        end else begin
            if (sel && !we) begin
                dout <= rd;
            end
            // A fresh TH edge outranks a same-cycle acknowledge.
            if (|ch_ev) begin
                ext_irq <= 1'b1;
            end else if (irq_ack) begin
                ext_irq <= 1'b0;
            end
        end
    end

    assign port1_in  = ch_in[0];
    assign port2_in  = ch_in[1];
    assign port1_dir = ch_dir[0];
    assign port2_dir = ch_dir[1];
    assign unused_p3 = ^{ch_in[2], ch_dir[2]};

endmodule

// File: tb/tb_md_io_regs.sv
// tb_md_io_regs: directed + randomized checks of md_io_regs
// against a register-map level reference model.
module tb_md_io_regs;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pal;
    logic       sel;
    logic       we;
    logic [3:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic [6:0] port1_pins;
    logic [6:0] port2_pins;
    logic [6:0] port1_in;
    logic [6:0] port2_in;
    logic [6:0] port1_dir;
    logic [6:0] port2_dir;
    logic       ext_irq;
    logic       irq_ack;

    always #5 clk = ~clk;

    md_io_regs #(.EXPORT(1'b1), .HW_VER(4'd0)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .PAL        (pal),
        .sel        (sel),
        .we         (we),
        .addr       (addr),
        .din        (din),
        .dout       (dout),
        .port1_pins (port1_pins),
        .port2_pins (port2_pins),
        .port1_in   (port1_in),
        .port2_in   (port2_in),
        .port1_dir  (port1_dir),
        .port2_dir  (port2_dir),
        .ext_irq    (ext_irq),
        .irq_ack    (irq_ack)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] m_data  [3];
    logic [7:0] m_ctrl  [3];
    logic [7:0] m_tx    [3];
    logic [7:0] m_sctrl [3];
    logic [7:0] m_dout;
    logic       m_irq;
    logic       m_prev  [2];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int p = 0; p < 3; p++) begin
            m_data[p]  = 8'h00;
            m_ctrl[p]  = 8'h00;
            m_tx[p]    = 8'hFF;
            m_sctrl[p] = 8'h00;
        end
        m_prev[0] = 1'b1;
        m_prev[1] = 1'b1;
        m_dout    = 8'h00;
        m_irq     = 1'b0;
    endfunction

    function automatic logic [7:0] model_read(input int a,
                                              input logic [6:0] p1,
                                              input logic [6:0] p2);
        logic [6:0] pins;
        logic [7:0] v;
        int p;
        if (a == 0) return {1'b1, pal, 1'b1, 1'b0, 4'h0};
        if (a <= 3) begin
            p    = a - 1;
            pins = (p == 0) ? p1 : (p == 1) ? p2 : 7'h7F;
            v[7] = m_data[p][7];
            for (int b = 0; b < 7; b++)
                v[b] = m_ctrl[p][b] ? m_data[p][b] : pins[b];
            return v;
        end
        if (a <= 6) return m_ctrl[a - 4];
        p = (a - 7) / 3;
        case ((a - 7) % 3)
            0:       return m_tx[p];
            1:       return 8'h00;
            default: return m_sctrl[p] & 8'hF8;
        endcase
    endfunction

    function automatic void model_write(input int a, input logic [7:0] d);
        int p;
        if (a == 0) return;
        if (a <= 3) begin
            m_data[a - 1] = d;
            return;
        end
        if (a <= 6) begin
            m_ctrl[a - 4] = d;
            return;
        end
        p = (a - 7) / 3;
        case ((a - 7) % 3)
            0:       m_tx[p] = d;
            1:       ;
            default: m_sctrl[p] = d;
        endcase
    endfunction

    // One bus cycle: drive at negedge, advance the model, compare after the edge.
    task automatic cyc(input bit s, input bit w, input logic [3:0] a,
                       input logic [7:0] d, input logic [6:0] p1,
                       input logic [6:0] p2, input bit ack);
        logic [7:0] rd;
        logic [6:0] pv [2];
        bit ev;
        @(negedge clk);
        sel = s; we = w; addr = a; din = d;
        port1_pins = p1; port2_pins = p2; irq_ack = ack;
        rd    = model_read(int'(a), p1, p2);
        pv[0] = p1;
        pv[1] = p2;
        ev    = 1'b0;
        for (int p = 0; p < 2; p++) begin
            if (m_ctrl[p][7] && !m_ctrl[p][6] && m_prev[p] && !pv[p][6])
                ev = 1'b1;
            m_prev[p] = pv[p][6];
        end
        if (s && !w) m_dout = rd;
        if (s && w) model_write(int'(a), d);
        if (ev) m_irq = 1'b1;
        else if (ack) m_irq = 1'b0;
        @(posedge clk);
        #1;
        check("dout", dout, m_dout);
        check("ext_irq", ext_irq, m_irq);
        check("port1_in", port1_in, m_data[0][6:0]);
        check("port2_in", port2_in, m_data[1][6:0]);
        check("port1_dir", port1_dir, m_ctrl[0][6:0]);
        check("port2_dir", port2_dir, m_ctrl[1][6:0]);
    endtask

    initial begin
        reset_n = 1'b0; pal = 1'b0; sel = 1'b0; we = 1'b0;
        addr = '0; din = '0; irq_ack = 1'b0;
        port1_pins = 7'h7F; port2_pins = 7'h7F;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", dout, 8'h00);
        check("rst_irq", ext_irq, 1'b0);
        check("rst_p1in", port1_in, 7'h00);
        check("rst_p2dir", port2_dir, 7'h00);
        @(negedge clk);
        reset_n = 1'b1;

        // First access right after release, VERSION with PAL=0.
        cyc(1, 0, 4'd0, 8'h00, 7'h7F, 7'h7F, 0);
        check("version", dout, 8'hA0);
        cyc(1, 1, 4'd0, 8'h33, 7'h7F, 7'h7F, 0);
        cyc(1, 0, 4'd0, 8'h00, 7'h7F, 7'h7F, 0);
        check("version_wr", dout, 8'hA0);
        cyc(0, 0, 4'd0, 8'h00, 7'h7F, 7'h7F, 0);
        check("dout_hold", dout, 8'hA0);

        // TH interrupt on port 2.
        cyc(1, 1, 4'd5, 8'h80, 7'h7F, 7'h7F, 0);
        cyc(0, 0, 4'd0, 8'h00, 7'h7F, 7'h3F, 0);
        check("irq_set", ext_irq, 1'b1);
        cyc(0, 0, 4'd0, 8'h00, 7'h7F, 7'h3F, 0);
        check("irq_held", ext_irq, 1'b1);
        cyc(1, 1, 4'd5, 8'h00, 7'h7F, 7'h7F, 0);
        check("irq_ctrl_clr", ext_irq, 1'b1);
        cyc(0, 0, 4'd0, 8'h00, 7'h7F, 7'h7F, 1);
        check("irq_ack", ext_irq, 1'b0);
        cyc(1, 1, 4'd5, 8'hC0, 7'h7F, 7'h7F, 0);
        cyc(0, 0, 4'd0, 8'h00, 7'h7F, 7'h3F, 0);
        check("irq_th_out", ext_irq, 1'b0);

        // Ack coincident with a new edge on port 1.
        cyc(1, 1, 4'd4, 8'h80, 7'h7F, 7'h7F, 0);
        cyc(0, 0, 4'd0, 8'h00, 7'h3F, 7'h7F, 0);
        cyc(0, 0, 4'd0, 8'h00, 7'h7F, 7'h7F, 0);
        cyc(0, 0, 4'd0, 8'h00, 7'h3F, 7'h7F, 1);
        check("irq_ack_race", ext_irq, 1'b1);
        cyc(0, 0, 4'd0, 8'h00, 7'h3F, 7'h7F, 1);
        check("irq_ack2", ext_irq, 1'b0);

        // Mixed output/input read of DATA1.
        cyc(1, 1, 4'd4, 8'h40, 7'h3F, 7'h7F, 0);
        cyc(1, 1, 4'd1, 8'h40, 7'h3F, 7'h7F, 0);
        cyc(1, 0, 4'd1, 8'h00, 7'h3F, 7'h7F, 0);
        check("data1_rd", dout, 8'h7F);
        check("p1_in", port1_in, 7'h40);
        check("p1_dir", port1_dir, 7'h40);

        // Serial registers of port 1.
        cyc(1, 1, 4'd7, 8'h5A, 7'h7F, 7'h7F, 0);
        cyc(1, 1, 4'd9, 8'hFF, 7'h7F, 7'h7F, 0);
        cyc(1, 1, 4'd8, 8'h12, 7'h7F, 7'h7F, 0);
        cyc(1, 0, 4'd7, 8'h00, 7'h7F, 7'h7F, 0);
        check("tx1_rd", dout, 8'h5A);
        cyc(1, 0, 4'd9, 8'h00, 7'h7F, 7'h7F, 0);
        check("sctrl1_rd", dout, 8'hF8);
        cyc(1, 0, 4'd8, 8'h00, 7'h7F, 7'h7F, 0);
        check("rx1_rd", dout, 8'h00);
        cyc(1, 0, 4'd3, 8'h00, 7'h7F, 7'h7F, 0);
        check("data3_rd", dout, 8'h7F);

        // Reset pulse in the middle of a read with an irq pending.
        cyc(1, 1, 4'd4, 8'h80, 7'h7F, 7'h7F, 0);
        cyc(1, 1, 4'd1, 8'h55, 7'h3F, 7'h7F, 0);
        cyc(1, 0, 4'd1, 8'h00, 7'h7F, 7'h7F, 0);
        check("pre_rst_irq", ext_irq, 1'b1);
        @(negedge clk);
        sel = 1'b1; we = 1'b0; addr = 4'd1;
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        check("arst_dout", dout, 8'h00);
        @(posedge clk);
        #1;
        check("mid_rst_dout", dout, 8'h00);
        check("mid_rst_irq", ext_irq, 1'b0);
        check("mid_rst_p1in", port1_in, 7'h00);
        @(negedge clk);
        sel = 1'b0;
        reset_n = 1'b1;
        cyc(0, 0, 4'd0, 8'h00, 7'h7F, 7'h7F, 0);
        check("post_rst_dout", dout, 8'h00);
        cyc(1, 0, 4'd4, 8'h00, 7'h7F, 7'h7F, 0);
        check("post_rst_ctrl1", dout, 8'h00);
        cyc(1, 0, 4'd7, 8'h00, 7'h7F, 7'h7F, 0);
        check("post_rst_tx1", dout, 8'hFF);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 63) == 0) pal = 1'(($urandom & 1));
            cyc(1'($urandom_range(0, 3) != 0), 1'($urandom & 1),
                4'($urandom), 8'($urandom), 7'($urandom), 7'($urandom),
                $urandom_range(0, 7) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/md_io_regs.md
MD_IO_REGS -- requirements
Module: md_io_regs

Interface
REQ-001 SHALL have parameter EXPORT, default 1, meaning the overseas/export flag reported in version bit 7.
REQ-002 SHALL have parameter HW_VER, default 4'd0, meaning the hardware version nibble reported in version bits 3:0.
REQ-003 SHALL have port clk, input, 1, the single system clock; all state SHALL be clocked on its rising edge.
REQ-004 SHALL have port reset_n, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port PAL, input, 1, the video standard flag reported in version bit 6.
REQ-006 SHALL have port sel, input, 1, the register access strobe, one cycle per access.
REQ-007 SHALL have port we, input, 1; 1 = write, 0 = read.
REQ-008 SHALL have port addr, input, 4, the register index (68k A4:A1).
REQ-009 SHALL have port din, input, 8, the write data.
REQ-010 SHALL have port dout, output, 8, the registered read data.
REQ-011 SHALL have ports port1_pins and port2_pins, input, 7 each, the pad pin levels from the controller input mux.
REQ-012 SHALL have ports port1_in, port2_in (data latch bits 6:0) and port1_dir, port2_dir (ctrl bits 6:0), output, 7 each, going to the controller input mux.
REQ-013 SHALL have port ext_irq, output, 1, the level-2 external interrupt request.
REQ-014 SHALL have port irq_ack, input, 1, the interrupt acknowledge.

Function
REQ-015 Register map SHALL be: 0 VERSION; 1-3 DATA1-3; 4-6 CTRL1-3; 7/10/13 TXDATA1-3; 8/11/14 RXDATA1-3; 9/12/15 SCTRL1-3.
REQ-016 VERSION SHALL read {EXPORT, PAL, 1'b1, 1'b0, HW_VER}; writes to it SHALL be ignored.
REQ-017 A write SHALL update the addressed register on the sel cycle; it SHALL be visible to a read issued on the next cycle.
REQ-018 A read SHALL present data on dout exactly 1 cycle after sel&!we; dout SHALL hold until the next read.
REQ-019 A DATAn read SHALL return bit 7 = data latch bit 7; for bits 6:0 the latch bit where CTRLn bit = 1 (output), else the pin level.
REQ-020 Port 3 pins SHALL read as 7'h7F.
REQ-021 portN_in SHALL equal DATAn[6:0]; portN_dir SHALL equal CTRLn[6:0]; both SHALL be registered, with no combinational path from din.
REQ-022 TXDATAn SHALL be read/write storage.
REQ-023 SCTRLn bits 7:3 SHALL be stored; bits 2:0 SHALL read 0.
REQ-024 RXDATAn SHALL read 8'h00; writes to it SHALL be ignored.
REQ-025 Per port 1/2, a TH event SHALL be a 1->0 change of pins[6] between consecutive cycles while CTRLn[7] = 1 and CTRLn[6] = 0.
REQ-026 A TH event SHALL set ext_irq on the following cycle; ext_irq SHALL stay set until an irq_ack cycle.
REQ-027 If irq_ack and a new TH event occur in the same cycle, the event SHALL win and ext_irq SHALL stay 1.
REQ-028 Clearing CTRLn[7] SHALL block new events only; it SHALL NOT clear a pending ext_irq.
REQ-029 A pin change in the cycle of a CTRLn write SHALL be judged with the old CTRLn value.

Reset
REQ-030 While reset_n = 0: DATA and CTRL SHALL be 8'h00; TXDATA 8'hFF; SCTRL 8'h00; dout 8'h00; ext_irq 0; portN_in and portN_dir 7'h00; TH history 1.
REQ-031 A reset during an access SHALL abort it; no register SHALL change and no stale dout SHALL appear after release.
REQ-032 The first sel SHALL be accepted on the first clock edge after reset_n rises.

Structure
REQ-033 Register index constants and the reset values SHALL live in shared package md_io_pkg.
REQ-034 Per-port DATA/CTRL/TX/SCTRL storage, read mux and TH edge detect SHALL be sub-module io_port_channel, instantiated 3 times.
REQ-035 The top level SHALL hold the address decode, VERSION, the dout register and the ext_irq flag.

Verification
REQ-036 EXPORT=1, PAL=0, read addr 0 -> dout 8'hA0 one cycle later.
REQ-037 CTRL1=8'h40, DATA1=8'h40, port1_pins=7'h3F, read DATA1 -> 8'h7F; port1_in=7'h40 and port1_dir=7'h40.
REQ-038 CTRL2=8'h80, port2_pins[6] 1->0 -> ext_irq=1 next cycle and held; irq_ack -> 0; with CTRL2=8'hC0 the same edge -> no irq.
REQ-039 irq_ack coincident with a new TH edge -> ext_irq remains 1.
REQ-040 Write TXDATA1=8'h5A, SCTRL1=8'hFF, RXDATA1=8'h12, read back -> 8'h5A, 8'hF8, 8'h00.
REQ-041 reset_n pulse low mid-read after DATA1/CTRL1 writes -> dout 8'h00, ext_irq 0, CTRL1 reads 8'h00, TXDATA1 reads 8'hFF.
